// File: rtl/feature_window_mac_if.sv
// feature_window_mac_if: beat/data/result bundle between the feature-memory
// side (master) and the window MAC (slave). Signal names follow the original
// flat port list so existing connections map one-to-one.
interface feature_window_mac_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int ACC_WIDTH    = 40
);
  logic                    enable;
  logic [DATA_WIDTH-1:0]   dina;
  logic [DATA_WIDTH-1:0]   dinb;
  logic [WEIGHT_WIDTH-1:0] wa;
  logic [WEIGHT_WIDTH-1:0] wb;
  logic [ACC_WIDTH-1:0]    bias;
  logic [ACC_WIDTH-1:0]    dout;
  logic                    dout_valid;
  logic                    done;

  modport master (
    output enable, dina, dinb, wa, wb, bias,
    input  dout, dout_valid, done
  );

  modport slave (
    input  enable, dina, dinb, wa, wb, bias,
    output dout, dout_valid, done
  );
endinterface

// File: rtl/feature_window_mac.sv
// feature_window_mac: multiply-accumulate over one KxK window across all input
// maps, two pixels per beat, emitting one biased result per window.
// Optional build macro FEATURE_WINDOW_MAC_RELU_EN clamps negative results to 0.
module feature_window_mac #(
  parameter int DATA_WIDTH    = 16,
  parameter int WEIGHT_WIDTH  = 16,
  parameter int ACC_WIDTH     = 40,
  parameter int KERNEL_WIDTH  = 5,
  parameter int IN_MAPS       = 4,
  parameter int READ_LATENCY  = 2,
  parameter int TOTAL_WINDOWS = 576
) (
  input  logic                 clk,
  input  logic                 reset,
  feature_window_mac_if.slave  bus
);

  localparam int unsigned KK     = KERNEL_WIDTH * KERNEL_WIDTH;
  localparam int unsigned PAIRS  = (KK + 1) / 2;
  localparam bit          ODD_KK = (KK % 2) == 1;
  localparam int unsigned BEAT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int unsigned MAP_W  = (IN_MAPS > 1) ? $clog2(IN_MAPS) : 1;
  localparam int unsigned WIN_W  = (TOTAL_WINDOWS > 1) ? $clog2(TOTAL_WINDOWS) : 1;
  localparam int unsigned PROD_W = DATA_WIDTH + WEIGHT_WIDTH;

  typedef enum logic {S_RUN, S_DONE} state_t;
  state_t state_q;

  logic [READ_LATENCY-1:0] vpipe_q;
  logic                    dv;

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [MAP_W-1:0]  map_q, map_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic beat_wrap, map_wrap, win_wrap;
  logic tag_first, tag_last, tag_odd_last, tag_final;

  logic signed [PROD_W-1:0]    prod_a, prod_b;
  logic signed [ACC_WIDTH-1:0] pa_d, pb_d;
  logic signed [ACC_WIDTH-1:0] pa_q, pb_q;
  logic s1_v_q, s1_first_q, s1_last_q, s1_final_q;

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic s2_last_q, s2_final_q;

  logic signed [ACC_WIDTH-1:0] sum_w, res_d;
  logic [ACC_WIDTH-1:0]        dout_q;
  logic                        dout_valid_q;

  assign dv = vpipe_q[READ_LATENCY-1];

  // Beat position tags, next counter values, stage-1 products and stage-3 result
  always_comb begin
    beat_wrap    = (beat_q == BEAT_W'(PAIRS - 1));
    map_wrap     = (map_q == MAP_W'(IN_MAPS - 1));
    win_wrap     = (win_q == WIN_W'(TOTAL_WINDOWS - 1));
    tag_first    = (beat_q == '0) && (map_q == '0);
    tag_last     = beat_wrap && map_wrap;
    tag_odd_last = ODD_KK && beat_wrap;
    tag_final    = tag_last && win_wrap;

    beat_d = beat_wrap ? '0 : beat_q + 1'b1;
    map_d  = map_q;
    if (beat_wrap) map_d = map_wrap ? '0 : map_q + 1'b1;
    win_d  = win_q;
    if (tag_last) win_d = win_wrap ? '0 : win_q + 1'b1;

    prod_a = $signed(bus.dina) * $signed(bus.wa);
    prod_b = $signed(bus.dinb) * $signed(bus.wb);
    pa_d   = ACC_WIDTH'(prod_a);
    pb_d   = tag_odd_last ? '0 : ACC_WIDTH'(prod_b);

    sum_w = acc_q + $signed(bus.bias);
`ifdef FEATURE_WINDOW_MAC_RELU_EN
    res_d = sum_w[ACC_WIDTH-1] ? '0 : sum_w;
`else
    res_d = sum_w;
`endif
  end

  // Delay accepted beats to their data-return edge and step beat/map/window counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpipe_q <= '0;
      beat_q  <= '0;
      map_q   <= '0;
      win_q   <= '0;
    end else begin
      vpipe_q[0] <= bus.enable && (state_q == S_RUN);
      for (int unsigned i = 1; i < READ_LATENCY; i++) vpipe_q[i] <= vpipe_q[i-1];
      if (dv) begin
        beat_q <= beat_d;
        map_q  <= map_d;
        win_q  <= win_d;
      end
    end
  end

  // Stage 1: register both products with the beat's position tags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pa_q       <= '0;
      pb_q       <= '0;
      s1_v_q     <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_final_q <= 1'b0;
    end else begin
      s1_v_q <= dv;
      if (dv) begin
        pa_q       <= pa_d;
        pb_q       <= pb_d;
        s1_first_q <= tag_first;
        s1_last_q  <= tag_last;
        s1_final_q <= tag_final;
      end
    end
  end

  // Stage 2: accumulate, restarting on the first beat of a window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      s2_last_q  <= 1'b0;
      s2_final_q <= 1'b0;
    end else begin
      if (s1_v_q) acc_q <= (s1_first_q ? '0 : acc_q) + pa_q + pb_q;
      s2_last_q  <= s1_v_q && s1_last_q;
      s2_final_q <= s1_v_q && s1_final_q;
    end
  end

  // Stage 3 and RUN/DONE: form the biased result and latch completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      state_q      <= S_RUN;
    end else begin
      dout_valid_q <= s2_last_q;
      if (s2_last_q) dout_q <= res_d;
      if (s2_final_q) state_q <= S_DONE;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.done       = (state_q == S_DONE);

endmodule

// File: tb/tb_feature_window_mac.sv
// tb_feature_window_mac: K=3, IN_MAPS=2, READ_LATENCY=2, TOTAL_WINDOWS=2.
// A queue-based reference model predicts dout/dout_valid/done every cycle;
// directed scenarios additionally pin literal results.
module tb_feature_window_mac;

  localparam int DW = 16, WW = 16, AW = 40;
  localparam int K = 3, MAPS = 2, L = 2, TW = 2;
  localparam int PAIRS = (K * K + 1) / 2;
  localparam int BPW = PAIRS * MAPS;

  logic clk = 1'b0;
  logic reset;

  feature_window_mac_if #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW)) bus ();

  feature_window_mac #(
    .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .KERNEL_WIDTH(K),
    .IN_MAPS(MAPS), .READ_LATENCY(L), .TOTAL_WINDOWS(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // ---------------- reference model ----------------
  int now = 0;
  int arr_t[$];
  int res_t[$];
  logic signed [AW-1:0] res_v[$];
  logic signed [AW-1:0] m_sum;
  int m_n, m_wins;
  bit m_done;
  logic signed [AW-1:0] exp_dout;
  bit exp_valid;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      arr_t.delete(); res_t.delete(); res_v.delete();
      m_sum = '0; m_n = 0; m_wins = 0; m_done = 0;
      exp_dout = '0; exp_valid = 0;
    end else begin
      bit accept;
      now++;
      accept = bus.enable && !m_done;
      exp_valid = 0;
      if (res_t.size() > 0 && res_t[0] == now) begin
        logic signed [AW-1:0] r;
        void'(res_t.pop_front());
        r = res_v.pop_front() + $signed(bus.bias);
`ifdef FEATURE_WINDOW_MAC_RELU_EN
        if (r < 0) r = '0;
`endif
        exp_dout = r;
        exp_valid = 1;
        m_wins++;
        if (m_wins == TW) m_done = 1;
      end
      if (arr_t.size() > 0 && arr_t[0] == now) begin
        longint pa, pb;
        int pos;
        void'(arr_t.pop_front());
        pos = m_n % BPW;
        pa = longint'($signed(bus.dina)) * longint'($signed(bus.wa));
        pb = ((pos % PAIRS) == PAIRS - 1 && (K * K) % 2 == 1) ? 0
             : longint'($signed(bus.dinb)) * longint'($signed(bus.wb));
        m_sum = m_sum + AW'(pa + pb);
        m_n++;
        if (pos == BPW - 1) begin
          res_t.push_back(now + 2);
          res_v.push_back(m_sum);
          m_sum = '0;
        end
      end
      if (accept) arr_t.push_back(now + L);
    end
  end

  // ---------------- per-cycle compare ----------------
  int pulses = 0;
  int pulse_cyc = 0;
  logic signed [AW-1:0] pulse_val = '0;

  always @(posedge clk) begin
    #2;
    if (!reset) begin
      check("dout_valid", 64'(bus.dout_valid), 64'(exp_valid));
      check("done", 64'(bus.done), 64'(m_done));
      check("dout", 64'($signed(bus.dout)), 64'(exp_dout));
      if (bus.dout_valid) begin
        pulses++;
        pulse_cyc = now;
        pulse_val = $signed(bus.dout);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int e_last = 0;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_data(input int a, input int b, input int xa, input int xb, input longint bi);
    bus.dina = DW'(a);
    bus.dinb = DW'(b);
    bus.wa   = WW'(xa);
    bus.wb   = WW'(xb);
    bus.bias = AW'(bi);
  endtask

  task automatic drive(input bit en);
    @(negedge clk);
    bus.enable = en;
    @(posedge clk);
    #1;
    if (en) e_last = now;
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int k = 0;
    while (pulses < target && k < budget) begin
      @(posedge clk);
      #3;
      k++;
    end
    check("pulse_wait", 64'(pulses >= target), 64'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    reset = 1'b1;
    bus.enable = 1'b0;
    set_data(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_dout", 64'(bus.dout), 64'(0));
    check("reset_valid", 64'(bus.dout_valid), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));

    // Baseline: 10 consecutive beats of all ones
    do_reset();
    set_data(1, 1, 1, 1, 0);
    p0 = pulses;
    repeat (BPW) drive(1'b1);
    wait_pulses(p0 + 1, 20);
    check("base_dout", 64'(pulse_val), 64'(18));
    check("base_latency", 64'(pulse_cyc - e_last), 64'(4));
    idle(6);
    check("base_pulses", 64'(pulses - p0), 64'(1));

    // Stalls: enable alternating
    do_reset();
    p0 = pulses;
    for (int i = 0; i < BPW; i++) begin
      drive(1'b1);
      drive(1'b0);
    end
    wait_pulses(p0 + 1, 20);
    check("stall_dout", 64'(pulse_val), 64'(18));
    check("stall_latency", 64'(pulse_cyc - e_last), 64'(4));
    check("stall_pulses", 64'(pulses - p0), 64'(1));

    // Negative bias
    do_reset();
    set_data(1, 1, 1, 1, -100);
    p0 = pulses;
    repeat (BPW) drive(1'b1);
    wait_pulses(p0 + 1, 20);
`ifdef FEATURE_WINDOW_MAC_RELU_EN
    check("relu_dout", 64'(pulse_val), 64'(0));
`else
    check("bias_dout", 64'(pulse_val), 64'(-82));
`endif

    // Signed multiply: 18 products of -3*2
    do_reset();
    set_data(-3, -3, 2, 2, 0);
    p0 = pulses;
    repeat (BPW) drive(1'b1);
    wait_pulses(p0 + 1, 20);
`ifdef FEATURE_WINDOW_MAC_RELU_EN
    check("signed_dout", 64'(pulse_val), 64'(0));
`else
    check("signed_dout", 64'(pulse_val), 64'(-108));
`endif

    // Reset mid-window discards partial work
    do_reset();
    set_data(7, 5, 3, 2, 0);
    p0 = pulses;
    repeat (6) drive(1'b1);
    do_reset();
    set_data(1, 1, 1, 1, 0);
    repeat (BPW) drive(1'b1);
    wait_pulses(p0 + 1, 20);
    check("rst_mid_pulses", 64'(pulses - p0), 64'(1));
    check("rst_mid_dout", 64'(pulse_val), 64'(18));

    // Completion after TW windows; extra enables are ignored
    do_reset();
    p0 = pulses;
    repeat (3 * BPW) drive(1'b1);
    idle(8);
    check("cmpl_pulses", 64'(pulses - p0), 64'(2));
    check("cmpl_dout", 64'(pulse_val), 64'(18));
    check("cmpl_done", 64'(bus.done), 64'(1));
    repeat (BPW) drive(1'b1);
    idle(8);
    check("cmpl_pulses_after", 64'(pulses - p0), 64'(2));
    check("cmpl_done_after", 64'(bus.done), 64'(1));

    // Randomized rounds against the model
    for (int r = 0; r < 15; r++) begin
      do_reset();
      for (int c = 0; c < 70; c++) begin
        @(negedge clk);
        bus.enable = ($urandom_range(0, 3) != 0);
        bus.dina = DW'($urandom);
        bus.dinb = DW'($urandom);
        bus.wa   = WW'($urandom);
        bus.wb   = WW'($urandom);
        bus.bias = AW'($signed($urandom)) <<< $urandom_range(0, 6);
      end
      bus.enable = 1'b0;
      idle(6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
